row_window_buffer: RTL and testbench
====================================

Name: row_window_buffer

Overview:
- Upstream feeder for the three-input median stage.
- Accepts a raster pixel stream, one 32-bit word per accepted beat.
- Holds the two previous rows in internal line storage. For every pixel from the third row of a frame onward, emits a vertically aligned column triple: row r-2, row r-1 and row r at the same column.
- Output words map directly onto the median stage's word0/word1/word2 inputs.

Parameters:
- WIDTH, 32, pixel word width in bits.
- ROW_LEN, 8, pixels per row; must be at least 2.
- COL_W, 3, column counter width; equals ceil(log2(ROW_LEN)).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_sof are valid this cycle.
- in_ready  output  1  block can accept a pixel this cycle.
- in_data  input  WIDTH  pixel word.
- in_sof  input  1  start of frame; qualifies the pixel as row 0, column 0.
- out_valid  output  1  out_word0..2 hold a valid triple.
- out_ready  input  1  consumer accepts the triple this cycle.
- out_word0  output  WIDTH  pixel from row r-2.
- out_word1  output  WIDTH  pixel from row r-1.
- out_word2  output  WIDTH  pixel from row r (current).
- out_col  output  COL_W  column index of the triple.

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-high.
- Reset values:
  - out_valid=0, out_word0..2=0, out_col=0.
  - Column counter=0, row state=FILL0.
  - Line storage contents are not reset.
- Accept condition: accept = in_valid && in_ready, where in_ready = !out_valid || out_ready. There is a single output register and no skid buffer; in_ready is combinational from out_valid/out_ready.
- Transfer: an output transfer occurs when out_valid && out_ready.
- Row state machine, advanced only on accept:
  - FILL0 (row 0): write pixel to line B[col]. Leaving column ROW_LEN-1 -> FILL1.
  - FILL1 (row 1): A[col]<=B[col]; B[col]<=pixel. Leaving column ROW_LEN-1 -> STREAM.
  - STREAM (row >= 2): register out_word0=A[col], out_word1=B[col], out_word2=pixel, out_col=col; set out_valid=1; then A[col]<=B[col], B[col]<=pixel. Remains in STREAM.
- Column counter:
  - Increments on accept.
  - Wraps from ROW_LEN-1 to 0.
  - Row transitions happen on the wrap.
- Line storage reads use the pre-update values of A[col] and B[col] in the same cycle the new values are written (read-before-write).
- in_sof on an accepted beat: the pixel is treated as column 0 of FILL0 regardless of the current state or column. It writes B[0]; the column becomes 1. No triple is emitted for it, and a pending out_valid is unaffected.
- in_sof on a non-accepted beat: ignored.
- out_valid clear: cleared on transfer unless a new STREAM accept occurs in the same cycle, in which case it stays 1 with the new triple.
- FILL accepts: never set out_valid. They may occur while out_valid=1 only if out_ready=1 in that cycle.
- Backpressure: while out_valid && !out_ready, in_ready=0. Output registers, counters and storage are frozen.
- Latency: one cycle from an accepted STREAM pixel to out_valid.
- Throughput: one triple per cycle with out_ready held high.
- Reset mid-frame: returns to FILL0, column 0, out_valid=0. The next two rows refill the storage.
- Arithmetic: no arithmetic on data; words pass through unmodified.

Decomposition:
- Shared package: WIDTH default, ROW_LEN default, and the row-state encoding constants FILL0=0, FILL1=1, STREAM=2.
- One natural sub-module: row_line_ram, a ROW_LEN x WIDTH register array with one asynchronous read port and one synchronous write port with enable. It is instantiated twice (A, B).

Test Plan:
- ROW_LEN=4, out_ready=1; stream pixels 1..12 with in_sof on pixel 1 -> no output for pixels 1..8; pixel 9 yields (1,5,9,col0); then (2,6,10,1), (3,7,11,2), (4,8,12,3).
- Continue the same frame with pixels 13..16 -> triples (5,9,13,0) .. (8,12,16,3), proving the line rotation.
- Hold out_ready=0 when the first triple appears for 3 cycles -> in_ready=0, triple (1,5,9,0) held stable; release -> next triple follows with no loss or duplication.
- Assert in_sof on pixel 11 mid-frame -> no triple for pixels 11..18; pixel 19 emits a triple built from pixels 11 and 15 (columns restart at 0).
- Assert rst during STREAM with out_valid=1 -> next cycle out_valid=0, words=0; the following 8 pixels produce no output.
- Randomly toggle in_valid/out_ready over 100 pixels -> output sequence matches a reference model exactly.

Source files
------------

// File: rtl/row_window_buffer_pkg.sv
// rtl/row_window_buffer_pkg.sv - shared defaults and row-state encoding for the row window buffer
package row_window_buffer_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int ROW_LEN_DEF = 8;

    // Row state: which of the first two rows is being captured, or steady-state streaming.
    typedef enum logic [1:0] {
        FILL0  = 2'd0,
        FILL1  = 2'd1,
        STREAM = 2'd2
    } row_state_e;

endpackage

// File: rtl/row_window_buffer_if.sv
// rtl/row_window_buffer_if.sv - pixel-in / column-triple-out handshake bundle
// Signals: in_valid/in_ready/in_data/in_sof (pixel stream into the buffer),
//          out_valid/out_ready/out_word0..2/out_col (column triple out of the buffer).
// slave  : the buffer's view (consumes pixels, produces triples).
// master : the surrounding view (produces pixels, consumes triples).
interface row_window_buffer_if #(
    parameter int WIDTH = 32,
    parameter int COL_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sof;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word0;
    logic [WIDTH-1:0] out_word1;
    logic [WIDTH-1:0] out_word2;
    logic [COL_W-1:0] out_col;

    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_word0, out_word1, out_word2, out_col
    );

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_word0, out_word1, out_word2, out_col
    );
endinterface

// File: rtl/row_line_ram.sv
// rtl/row_line_ram.sv - one row of pixel storage, async read, sync write with enable
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o asynchronous read port.
// Contents are intentionally not reset; the row state machine refills them after reset.
module row_line_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/row_window_buffer.sv
// rtl/row_window_buffer.sv - two-row line buffer emitting vertical column triples (r-2, r-1, r)
// Ports: clk, rst (synchronous, active-high); bus (slave view of row_window_buffer_if):
//        pixel input in_valid/in_ready/in_data/in_sof, triple output
//        out_valid/out_ready/out_word0..2/out_col.
// Line A holds row r-2, line B holds row r-1; each accepted pixel shifts its column B->A, pixel->B.
module row_window_buffer
    import row_window_buffer_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ROW_LEN = ROW_LEN_DEF,
    parameter int COL_W   = 3
) (
    input logic            clk,
    input logic            rst,
    row_window_buffer_if.slave bus
);
    row_state_e       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] word0_q, word0_d;
    logic [WIDTH-1:0] word1_q, word1_d;
    logic [WIDTH-1:0] word2_q, word2_d;
    logic [COL_W-1:0] out_col_q, out_col_d;

    logic             in_ready;
    logic             accept;
    logic             col_last;
    logic [COL_W-1:0] addr;
    logic             a_we, b_we;
    logic [WIDTH-1:0] a_rd, b_rd;

    // Single output register: a new pixel may enter only if the register is empty or draining.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign col_last = (col_q == COL_W'(ROW_LEN - 1));
    // A start-of-frame pixel always lands in column 0, whatever the counter says.
    assign addr     = bus.in_sof ? '0 : col_q;

    // Line A takes B's pre-write value: async read of B sees the old contents this cycle.
    row_line_ram #(.WIDTH(WIDTH), .DEPTH(ROW_LEN), .AW(COL_W)) u_line_a (
        .clk     (clk),
        .we_i    (a_we),
        .waddr_i (addr),
        .wdata_i (b_rd),
        .raddr_i (addr),
        .rdata_o (a_rd)
    );

    row_line_ram #(.WIDTH(WIDTH), .DEPTH(ROW_LEN), .AW(COL_W)) u_line_b (
        .clk     (clk),
        .we_i    (b_we),
        .waddr_i (addr),
        .wdata_i (bus.in_data),
        .raddr_i (addr),
        .rdata_o (b_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            word0_q     <= '0;
            word1_q     <= '0;
            word2_q     <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            word2_q     <= word2_d;
            out_col_q   <= out_col_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        word0_d     = word0_q;
        word1_d     = word1_q;
        word2_d     = word2_q;
        out_col_d   = out_col_q;
        a_we        = 1'b0;
        b_we        = 1'b0;

        if (accept) begin
            if (bus.in_sof) begin
                state_d = FILL0;
                col_d   = COL_W'(1);
                b_we    = 1'b1;
            end else begin
                col_d = col_last ? '0 : col_q + 1'b1;
                unique case (state_q)
                    FILL0: begin
                        b_we = 1'b1;
                        if (col_last) state_d = FILL1;
                    end
                    FILL1: begin
                        a_we = 1'b1;
                        b_we = 1'b1;
                        if (col_last) state_d = STREAM;
                    end
                    STREAM: begin
                        a_we        = 1'b1;
                        b_we        = 1'b1;
                        out_valid_d = 1'b1;
                        word0_d     = a_rd;
                        word1_d     = b_rd;
                        word2_d     = bus.in_data;
                        out_col_d   = col_q;
                    end
                    default: state_d = FILL0;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word0 = word0_q;
    assign bus.out_word1 = word1_q;
    assign bus.out_word2 = word2_q;
    assign bus.out_col   = out_col_q;
endmodule

// File: tb/tb_row_window_buffer.sv
// tb/tb_row_window_buffer.sv - directed and randomized self-checking bench for row_window_buffer
module tb_row_window_buffer;
    localparam int W  = 32;
    localparam int RL = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    row_window_buffer_if #(.WIDTH(W), .COL_W(CW)) bus ();

    row_window_buffer #(.WIDTH(W), .ROW_LEN(RL), .COL_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] obs_t();
        return {29'd0, bus.out_valid, bus.out_word0, bus.out_word1, bus.out_word2, bus.out_col};
    endfunction

    function automatic logic [127:0] tri_t(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [1:0] col);
        return {29'd0, 1'b1, a, b, c, col};
    endfunction

    task automatic send(input logic [31:0] d, input logic sof);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    // reference model state for the randomized phase
    logic [31:0] m_a [RL];
    logic [31:0] m_b [RL];
    int          m_state, m_col, nacc;
    logic        m_valid, m_ready, acc;
    logic [31:0] m_w0, m_w1, m_w2;
    logic [1:0]  m_oc;
    logic        sof_pending;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sof    = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        chk("reset_outputs", obs_t(), 128'd0);
        chk("reset_in_ready", {127'd0, bus.in_ready}, 128'd1);

        // rows 0 and 1 fill the lines, then stream
        for (int p = 1; p <= 8; p++) begin
            send(p, p == 1);
            chk($sformatf("fill_no_out_p%0d", p), {127'd0, bus.out_valid}, 128'd0);
        end
        for (int p = 9; p <= 16; p++) begin
            send(p, 1'b0);
            chk($sformatf("stream_p%0d", p), obs_t(),
                tri_t(p - 8, p - 4, p, 2'((p - 9) % 4)));
        end

        // backpressure hold on the first triple of a new frame
        for (int p = 1; p <= 9; p++) send(p, p == 1);
        chk("hold_first", obs_t(), tri_t(1, 5, 9, 0));
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 10;
        #1;
        chk("hold_in_ready_low", {127'd0, bus.in_ready}, 128'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold_stable", obs_t(), tri_t(1, 5, 9, 0));
            chk("hold_ready", {127'd0, bus.in_ready}, 128'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_ready", {127'd0, bus.in_ready}, 128'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("release_p10", obs_t(), tri_t(2, 6, 10, 1));
        send(11, 1'b0);
        chk("release_p11", obs_t(), tri_t(3, 7, 11, 2));
        send(12, 1'b0);
        chk("release_p12", obs_t(), tri_t(4, 8, 12, 3));

        // start-of-frame in mid-frame restarts the fill
        for (int p = 1; p <= 10; p++) send(p, p == 1);
        chk("sof_pre_p10", obs_t(), tri_t(2, 6, 10, 1));
        for (int p = 11; p <= 18; p++) begin
            send(p, p == 11);
            chk($sformatf("sof_refill_p%0d", p), {127'd0, bus.out_valid}, 128'd0);
        end
        send(19, 1'b0);
        chk("sof_p19", obs_t(), tri_t(11, 15, 19, 0));
        send(20, 1'b0);
        chk("sof_p20", obs_t(), tri_t(12, 16, 20, 1));

        // reset while a triple is pending
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_outputs", obs_t(), 128'd0);
        for (int p = 21; p <= 28; p++) begin
            send(p, 1'b0);
            chk($sformatf("midreset_no_out_p%0d", p), {127'd0, bus.out_valid}, 128'd0);
        end
        send(29, 1'b0);
        chk("midreset_p29", obs_t(), tri_t(21, 25, 29, 0));

        // randomized handshakes against a cycle-level reference model
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_state = 0; m_col = 0; m_valid = 1'b0; nacc = 0; sof_pending = 1'b1;
        m_w0 = '0; m_w1 = '0; m_w2 = '0; m_oc = '0;
        for (int cyc = 0; cyc < 3000 && nacc < 100; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_data   = $urandom;
            bus.in_sof    = sof_pending;
            #1;
            m_ready = !m_valid || bus.out_ready;
            chk("rand_in_ready", {127'd0, bus.in_ready}, {127'd0, m_ready});
            acc = bus.in_valid && m_ready;
            m_valid = m_valid && !bus.out_ready;
            if (acc) begin
                nacc++;
                if (bus.in_sof) begin
                    m_b[0] = bus.in_data;
                    m_col = 1; m_state = 0; sof_pending = 1'b0;
                end else begin
                    if (m_state == 2) begin
                        m_w0 = m_a[m_col]; m_w1 = m_b[m_col]; m_w2 = bus.in_data;
                        m_oc = 2'(m_col); m_valid = 1'b1;
                    end
                    if (m_state != 0) m_a[m_col] = m_b[m_col];
                    m_b[m_col] = bus.in_data;
                    if (m_col == RL - 1) begin
                        m_col = 0;
                        if (m_state < 2) m_state++;
                    end else begin
                        m_col++;
                    end
                end
            end
            @(posedge clk); #1;
            if (m_valid) chk("rand_triple", obs_t(), tri_t(m_w0, m_w1, m_w2, m_oc));
            else chk("rand_idle", {127'd0, bus.out_valid}, 128'd0);
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        chk("rand_accept_count", 128'(nacc), 128'd100);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
